// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: requester, memory and debug signals of the two-port memory arbiter
interface mem_bus_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          m0_req, m1_req, m0_we, m1_we;
  logic [AW-1:0] m0_addr, m1_addr;
  logic [DW-1:0] m0_wdata, m1_wdata;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid;
  logic [DW-1:0] m0_rdata, m1_rdata;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  logic          mem_we, mem_en;
  logic [1:0]    dbg_owner;
  modport slave (
    input  m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    output m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_addr, mem_wdata, mem_we, mem_en, dbg_owner
  );
  modport master (
    output m0_req, m1_req, m0_we, m1_we, m0_addr, m1_addr, m0_wdata, m1_wdata, mem_rdata,
    input  m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_rdata, m1_rdata,
           mem_addr, mem_wdata, mem_we, mem_en, dbg_owner
  );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: two-port round-robin arbiter for a single-ported data memory; MEM_ARB_BURST_EN enables multi-beat tenures
module mem_bus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int BURST_LEN = 4
) (
  input logic clk,
  input logic rst,
  mem_bus_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2} state_t;
  state_t state_q, state_d;
  logic last_q, last_d, rvalid0_q, rvalid1_q;
  logic own0, own1, owner_req, other_req, last_beat, tend;
  if (BURST_LEN < 1 || BURST_LEN > 16) begin : g_bad_len
    $error("BURST_LEN must be within 1..16");
  end
  assign own0 = state_q == OWN0;
  assign own1 = state_q == OWN1;
  assign owner_req = own0 ? bus.m0_req : own1 & bus.m1_req;
  assign other_req = own0 ? bus.m1_req : bus.m0_req;
  assign tend = !owner_req | last_beat;
  assign bus.m0_gnt = own0 & bus.m0_req;
  assign bus.m1_gnt = own1 & bus.m1_req;
  assign bus.mem_en = owner_req;
  assign bus.mem_we = owner_req & (own0 ? bus.m0_we : bus.m1_we);
  assign bus.mem_addr = own0 ? bus.m0_addr : own1 ? bus.m1_addr : {AW{1'b0}};
  assign bus.mem_wdata = own0 ? bus.m0_wdata : own1 ? bus.m1_wdata : {DW{1'b0}};
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.m0_rdata = bus.mem_rdata;
  assign bus.m1_rdata = bus.mem_rdata;
  assign bus.dbg_owner = state_q;
`ifdef MEM_ARB_BURST_EN
  logic [3:0] cnt_q, cnt_d;
  assign last_beat = cnt_q == 4'(BURST_LEN - 1);
  assign cnt_d = (state_q == IDLE || tend) ? 4'd0 : cnt_q + 4'd1;
  // beat counter within the current tenure, cleared whenever ownership is given up
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= 4'd0;
    else cnt_q <= cnt_d;
`else
  assign last_beat = 1'b1;
`endif
  // IDLE arbitrates with the round-robin pointer; an owner hands over straight to a waiting peer
  always_comb begin
    state_d = state_q == IDLE ? (bus.m0_req & bus.m1_req ? (last_q ? OWN0 : OWN1) :
                                 bus.m0_req ? OWN0 : bus.m1_req ? OWN1 : IDLE) :
              !tend ? state_q : !other_req ? IDLE : own0 ? OWN1 : OWN0;
    last_d = (state_q != IDLE && tend) ? own1 : last_q;
  end
  // state, round-robin pointer and one-cycle read-response flags
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q <= IDLE;
      last_q <= 1'b1;
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q <= last_d;
      rvalid0_q <= bus.m0_gnt & !bus.m0_we;
      rvalid1_q <= bus.m1_gnt & !bus.m1_we;
    end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: scoreboard bench with a tenure-level arbitration model and a reference memory
module tb_mem_bus_arbiter;
`ifdef MEM_ARB_BURST_EN
  localparam int BLEN = 4;
`else
  localparam int BLEN = 1;
`endif
  typedef struct { int cyc; logic [31:0] data; } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  mem_bus_arbiter_if #(.AW(32), .DW(32)) bus ();
  mem_bus_arbiter #(.AW(32), .DW(32), .BURST_LEN(4)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  logic [31:0] tb_mem [256];
  logic [31:0] ref_mem [256];
  exp_t q0[$], q1[$];
  exp_t e;
  int total = 0, bad = 0, cyc = 0;
  int own = 0, left = BLEN;
  bit lst = 1'b1;
  bit r0, r1, eg0, eg1, rr, ro, w0, w1;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    if (bus.mem_en) begin
      if (bus.mem_we) tb_mem[bus.mem_addr[9:2]] <= bus.mem_wdata;
      else bus.mem_rdata <= tb_mem[bus.mem_addr[9:2]];
    end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
    end
  endtask

  task automatic set_cmd(input int p, input bit r, input bit w, input logic [31:0] a, input logic [31:0] d);
    if (p == 0) begin
      bus.m0_req = r; bus.m0_we = w; bus.m0_addr = a; bus.m0_wdata = d;
    end else begin
      bus.m1_req = r; bus.m1_we = w; bus.m1_addr = a; bus.m1_wdata = d;
    end
  endtask

  function automatic bit gnt_of(input int p);
    return p == 0 ? bus.m0_gnt : bus.m1_gnt;
  endfunction

  task automatic idle(input int p);
    set_cmd(p, 1'b0, 1'b0, 32'd0, 32'd0);
  endtask

  task automatic beat(input int p, input bit w, input logic [31:0] a, input logic [31:0] d);
    int t = 0;
    set_cmd(p, 1'b1, w, a, d);
    do begin @(negedge clk); t++; end while (!gnt_of(p) && t < 64);
    if (gnt_of(p)) begin
      if (w) ref_mem[a[9:2]] = d;
      else if (p == 0) q0.push_back(exp_t'{cyc, ref_mem[a[9:2]]});
      else q1.push_back(exp_t'{cyc, ref_mem[a[9:2]]});
    end else begin
      total++;
      bad++;
      $display("FAIL gnt_timeout port=%0d got=0 want=1", p);
    end
    @(posedge clk); #1;
  endtask

  task automatic traffic(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      beat(p, 1'($urandom_range(0, 1)), {22'd0, 8'($urandom_range(0, 255)), 2'b00}, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        idle(p);
        repeat ($urandom_range(1, 3)) begin @(posedge clk); #1; end
      end
    end
    idle(p);
  endtask

  // monitor: compares grants, memory command and read responses against the model once per cycle
  always @(negedge clk) begin
    #2;
    if (!rst) begin
      chk("rst_m0_gnt", bus.m0_gnt, 0);
      chk("rst_m1_gnt", bus.m1_gnt, 0);
      chk("rst_m0_rvalid", bus.m0_rvalid, 0);
      chk("rst_m1_rvalid", bus.m1_rvalid, 0);
      chk("rst_mem_en", bus.mem_en, 0);
      chk("rst_mem_we", bus.mem_we, 0);
      chk("rst_dbg_owner", bus.dbg_owner, 0);
      own = 0; lst = 1'b1; left = BLEN;
      q0.delete(); q1.delete();
    end else begin
      r0 = bus.m0_req; r1 = bus.m1_req;
      eg0 = own == 1 && r0;
      eg1 = own == 2 && r1;
      chk("m0_gnt", bus.m0_gnt, eg0);
      chk("m1_gnt", bus.m1_gnt, eg1);
      chk("dbg_owner", bus.dbg_owner, own);
      chk("mem_en", bus.mem_en, eg0 | eg1);
      chk("mem_we", bus.mem_we, eg0 ? bus.m0_we : eg1 & bus.m1_we);
      if (eg0) chk("mem_addr0", bus.mem_addr, bus.m0_addr);
      if (eg1) chk("mem_addr1", bus.mem_addr, bus.m1_addr);
      if (eg0 && bus.m0_we) chk("mem_wdata0", bus.mem_wdata, bus.m0_wdata);
      if (eg1 && bus.m1_we) chk("mem_wdata1", bus.mem_wdata, bus.m1_wdata);
      if (own == 0) begin
        chk("idle_addr", bus.mem_addr, 0);
        chk("idle_wdata", bus.mem_wdata, 0);
      end
      w0 = q0.size() > 0 && q0[0].cyc == cyc - 1;
      w1 = q1.size() > 0 && q1[0].cyc == cyc - 1;
      chk("m0_rvalid", bus.m0_rvalid, w0);
      chk("m1_rvalid", bus.m1_rvalid, w1);
      if (w0) begin e = q0.pop_front(); chk("m0_rdata", bus.m0_rdata, e.data); end
      if (w1) begin e = q1.pop_front(); chk("m1_rdata", bus.m1_rdata, e.data); end
      if (own == 0) begin
        own = (r0 && r1) ? (lst ? 1 : 2) : r0 ? 1 : r1 ? 2 : 0;
        left = BLEN;
      end else begin
        rr = own == 1 ? r0 : r1;
        ro = own == 1 ? r1 : r0;
        if (!rr || left == 1) begin
          lst = own == 2;
          left = BLEN;
          own = !ro ? 0 : own == 1 ? 2 : 1;
        end else left--;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) begin
      tb_mem[i] = (i * 32'h01010101) ^ 32'h5A000000;
      ref_mem[i] = (i * 32'h01010101) ^ 32'h5A000000;
    end
    tb_mem[4] = 32'hCAFE0001;
    ref_mem[4] = 32'hCAFE0001;
    idle(0);
    idle(1);
    repeat (3) @(posedge clk);
    #1;
    chk("init_m0_gnt", bus.m0_gnt, 0);
    chk("init_mem_en", bus.mem_en, 0);
    chk("init_dbg_owner", bus.dbg_owner, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    beat(0, 1'b0, 32'h10, 32'd0);
    idle(0);
    chk("first_rvalid", bus.m0_rvalid, 1);
    chk("first_rdata", bus.m0_rdata, 32'hCAFE0001);
    repeat (2) begin @(posedge clk); #1; end
    fork
      begin for (int i = 0; i < 4; i++) beat(0, 1'b0, 32'(i * 4), 32'd0); idle(0); end
      begin for (int i = 0; i < 4; i++) beat(1, 1'b0, 32'(64 + i * 4), 32'd0); idle(1); end
    join
    fork
      begin for (int i = 0; i < 4; i++) beat(1, 1'b1, 32'(256 + i * 4), $urandom); idle(1); end
      begin beat(0, 1'b0, 32'h104, 32'd0); idle(0); end
    join
    fork
      begin beat(0, 1'b0, 32'h08, 32'd0); beat(0, 1'b0, 32'h0C, 32'd0); idle(0); end
      begin for (int i = 0; i < 3; i++) beat(1, 1'b0, 32'(128 + i * 4), 32'd0); idle(1); end
    join
    beat(1, 1'b1, 32'h20, 32'hA5A5A5A5);
    idle(1);
    beat(0, 1'b0, 32'h20, 32'd0);
    idle(0);
    chk("coh_rvalid", bus.m0_rvalid, 1);
    chk("coh_rdata", bus.m0_rdata, 32'hA5A5A5A5);
    fork
      traffic(0, 150);
      traffic(1, 150);
    join
    repeat (3) begin @(posedge clk); #1; end
    beat(1, 1'b0, 32'h44, 32'd0);
    idle(1);
    chk("pre_rst_m1_rvalid", bus.m1_rvalid, 1);
    rst = 1'b0;
    #1;
    chk("async_m1_rvalid", bus.m1_rvalid, 0);
    chk("async_dbg_owner", bus.dbg_owner, 0);
    chk("async_mem_en", bus.mem_en, 0);
    repeat (2) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    fork
      begin beat(0, 1'b0, 32'h10, 32'd0); idle(0); end
      begin beat(1, 1'b0, 32'h14, 32'd0); idle(1); end
    join
    repeat (4) begin @(posedge clk); #1; end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Two-port round-robin arbiter that shares the single-ported data memory between the core's load/store port (port 0) and a second bus master (port 1, a DMA or debug loader). It sits between the requesters and the memory, driving `mem_addr`, `mem_wdata` and `mem_we` toward the memory and returning `mem_rdata` to the owning port. Requesters use a req/gnt handshake, and the memory has a fixed 1-cycle read latency.

## Interface
Parameters:
- `AW`, 32: address width.
- `DW`, 32: data width.
- `BURST_LEN`, 4: maximum beats per grant tenure when bursting is compiled in. Legal range is 1..16.

Ports:
- `clk` input 1: the single clock. Everything is rising-edge.
- `rst` input 1: asynchronous, active-low reset.
- `m0_req`, `m1_req` input 1: request. Held with its command until the port samples its `gnt` high.
- `m0_we`, `m1_we` input 1: 1 means write, 0 means read.
- `m0_addr`, `m1_addr` input AW: beat address.
- `m0_wdata`, `m1_wdata` input DW: write data.
- `m0_gnt`, `m1_gnt` output 1: beat accepted this cycle. Combinational from state and req.
- `m0_rvalid`, `m1_rvalid` output 1: read data valid. Registered.
- `m0_rdata`, `m1_rdata` output DW: read data. Both carry `mem_rdata`; only qualified by rvalid.
- `mem_addr` output AW, `mem_wdata` output DW, `mem_we` output 1, `mem_en` output 1: memory command.
- `mem_rdata` input DW: memory read data, valid 1 cycle after a read beat.
- `dbg_owner` output 2: 0 = idle, 1 = port 0, 2 = port 1.

## Operation
- States are IDLE, OWN0 and OWN1. State is registered, and a pointer `last` records the port granted most recently.
- IDLE:
  - If exactly one req is high, the next state is that port's OWN state.
  - If both reqs are high, the port other than `last` wins.
  - No gnt is issued in IDLE.
- OWNn:
  - `gnt_n` = `req_n`. The other gnt is 0.
  - The memory command is muxed from port n.
  - `mem_en` = `req_n`, and `mem_we` = `req_n & we_n`.
  - A beat is a cycle with `req_n & gnt_n`. Each beat increments the 4-bit beat counter `cnt`.
- Tenure end occurs on either:
  - a cycle where `req_n` = 0, or
  - the beat where `cnt` = BURST_LEN-1.
- At tenure end:
  - `last` is set to n and `cnt` is cleared.
  - The next state is OWN(other) if the other req is high, otherwise IDLE.
  - There is no idle bubble on handover.
- A read beat sets `mn_rvalid` for exactly the next cycle. Writes produce no response.
- In IDLE, `mem_addr`, `mem_wdata`, `mem_we` and `mem_en` are all 0.
- `dbg_owner` reflects the current state.

## Timing
- Reset (`rst` = 0) acts immediately, without waiting for a clock edge:
  - state = IDLE, `last` = 1 (so port 0 wins the first contest), `cnt` = 0.
  - Both rvalid = 0, both gnt = 0.
  - `mem_en` = 0, `mem_we` = 0, `dbg_owner` = 0.
- Reset mid-tenure aborts the tenure and drops any pending rvalid. A write beat issued in the reset cycle is not guaranteed.
- Arbitration latency:
  - From IDLE, the first gnt comes 1 cycle after req rises.
  - At handover, the new owner's first gnt is in the cycle immediately after the old owner's last beat or req drop.
- Throughput is 1 beat/cycle within a tenure.
- Read latency is 1 cycle: rvalid is asserted the cycle after the beat.
- Back-to-back reads give continuous rvalid.
- If the owner drops req while the other port is idle, the next state is IDLE. A re-request then pays 1 cycle of latency.
- If `req_n` drops while an rvalid from its last beat is pending, that rvalid is still delivered.
- Without bursting, a tenure is always exactly 1 beat. Under continuous dual requests, grants alternate 0,1,0,1 with no bubbles.

## Configuration
- `MEM_ARB_BURST_EN`:
  - Defined: a tenure lasts up to BURST_LEN beats as described above.
  - Undefined: `cnt` is not instantiated. Every beat is a tenure end, which is equivalent to BURST_LEN = 1 regardless of the parameter.

## Test plan
- Reset and single port 0 read:
  - Stimulus: hold `rst` = 0, check all outputs are 0, then release. Port 0 reads `addr` 0x10 and memory returns 0xCAFE0001.
  - Required: gnt at cycle 2, `m0_rvalid` with `m0_rdata` = 0xCAFE0001 at cycle 3, `dbg_owner` 1→0.
- Simultaneous first requests:
  - Stimulus: `m0_req` and `m1_req` rise together.
  - Required: port 0 is granted first. With macro undefined, grants alternate 0,1,0,1 for 8 cycles with no bubbles.
- Burst (`MEM_ARB_BURST_EN`, BURST_LEN = 4):
  - Stimulus: port 1 writes continuously to 0x100..0x10C; port 0 requests in parallel.
  - Required: port 1 gets 4 consecutive beats with `mem_we` = 1, then port 0 is granted in the very next cycle.
- Early release:
  - Stimulus: port 0 drops req after 2 of 4 beats while `m1_req` = 1.
  - Required: OWN1 begins in the next cycle and `cnt` restarts at 0.
- Reset mid-read:
  - Stimulus: assert `rst` in the cycle after a port 1 read beat.
  - Required: `m1_rvalid` goes to 0 immediately, state is IDLE, and a subsequent simultaneous request grants port 0.
- Write/read coherence:
  - Stimulus: port 1 writes 0xA5A5A5A5 to 0x20, then port 0 reads 0x20.
  - Required: `m0_rdata` = 0xA5A5A5A5 with `m0_rvalid` asserted.
